// File: rtl/latch_ctrl_pkg.sv
// Shared encodings for the latch write controller: FSM state codes and counter width.
package latch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_OPEN  = ST_OPEN,
    S_HOLD  = ST_HOLD
  } state_t;

endpackage

// File: rtl/latch_wr_arbiter_rr_arbiter.sv
// Round-robin picker: rotate requests by the pointer, take the lowest set bit, rotate back.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     grant_en,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     gnt_valid
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0]     ptr;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDW-1:0]     off;
  logic [IDW:0]       sum;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_REQ];

  always_comb begin
    gnt_valid = 1'b0;
    off       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off       = IDW'(i);
        gnt_valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
    gnt_id = sum[IDW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_en && gnt_valid) begin
      ptr <= (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/latch_wr_arbiter.sv
// Shares one level-sensitive latch bank among N_REQ writers: grant, setup, enable pulse, hold, ack.
module latch_wr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      wdata,
  output logic [N_REQ-1:0]         ack,
  output logic                     lat_en,
  output logic [DW-1:0]            lat_d,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int GW = $clog2(N_REQ);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    gnt_id;
  logic             gnt_valid;
  logic             grant_en;

  // Requests are only considered while idle; the pointer advances only on an actual grant.
  assign grant_en = (state == S_IDLE);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant_en (grant_en),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lat_en   <= 1'b0;
      lat_d    <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ack    <= '0;
          lat_en <= 1'b0;
          if (gnt_valid) begin
            lat_d    <= wdata[gnt_id*DW +: DW];
            grant_id <= gnt_id;
            busy     <= 1'b1;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt    <= CNT_W'(EN_CYCLES);
          lat_en <= 1'b1;
          state  <= S_OPEN;
        end
        S_OPEN: begin
          cnt <= cnt - 1'b1;
          // Last enable cycle: close the latch and raise ack for the hold cycle.
          if (cnt == CNT_W'(1)) begin
            lat_en        <= 1'b0;
            ack[grant_id] <= 1'b1;
            state         <= S_HOLD;
          end
        end
        S_HOLD: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          lat_en <= 1'b0;
          ack    <= '0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Directed bench for latch_wr_arbiter: cycle table plus multi-cycle sequences on two instances.
module tb_latch_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req_b;
  logic [31:0] wdata, wdata_b;
  logic [3:0]  ack, ack_b;
  logic        lat_en, lat_en_b;
  logic [7:0]  lat_d, lat_d_b;
  logic [1:0]  grant_id, grant_id_b;
  logic        busy, busy_b;
  logic [7:0]  latch_q, latch_q_b;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  latch_wr_arbiter #(.N_REQ(4), .DW(8), .EN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .ack(ack),
    .lat_en(lat_en), .lat_d(lat_d), .grant_id(grant_id), .busy(busy)
  );

  latch_wr_arbiter #(.N_REQ(4), .DW(8), .EN_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .wdata(wdata_b), .ack(ack_b),
    .lat_en(lat_en_b), .lat_d(lat_d_b), .grant_id(grant_id_b), .busy(busy_b)
  );

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic [7:0] d;
    logic [3:0] ack;
    logic       busy;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock, then sample on the falling edge and update the latch models.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (lat_en)   latch_q   = lat_d;
    if (lat_en_b) latch_q_b = lat_d_b;
  endtask

  task automatic do_reset();
    req   = '0;
    req_b = '0;
    @(negedge clk);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int order[$];
    int budget;
    int en_cnt;

    req = '0; req_b = '0; wdata = '0; wdata_b = '0;
    latch_q = '0; latch_q_b = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_lat_en", 32'(lat_en), 0);
    chk("rst_busy",   32'(busy),   0);
    chk("rst_ack",    32'(ack),    0);
    chk("rst_lat_d",  32'(lat_d),  0);
    chk("rst_gid",    32'(grant_id), 0);
    do_reset();

    // Test 1 plus a second transaction from requester 1, cycle by cycle.
    wdata = {8'h00, 8'h00, 8'h5A, 8'hA5};
    tbl[0] = '{4'b0001, 1'b0, 8'hA5, 4'b0000, 1'b1, 2'd0};
    tbl[1] = '{4'b0001, 1'b1, 8'hA5, 4'b0000, 1'b1, 2'd0};
    tbl[2] = '{4'b0001, 1'b1, 8'hA5, 4'b0000, 1'b1, 2'd0};
    tbl[3] = '{4'b0001, 1'b0, 8'hA5, 4'b0001, 1'b1, 2'd0};
    tbl[4] = '{4'b0000, 1'b0, 8'hA5, 4'b0000, 1'b0, 2'd0};
    tbl[5] = '{4'b0010, 1'b0, 8'h5A, 4'b0000, 1'b1, 2'd1};
    tbl[6] = '{4'b0010, 1'b1, 8'h5A, 4'b0000, 1'b1, 2'd1};
    tbl[7] = '{4'b0010, 1'b1, 8'h5A, 4'b0000, 1'b1, 2'd1};
    tbl[8] = '{4'b0010, 1'b0, 8'h5A, 4'b0010, 1'b1, 2'd1};
    tbl[9] = '{4'b0000, 1'b0, 8'h5A, 4'b0000, 1'b0, 2'd1};
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      step();
      if (i == 4) chk("t1_latch_q", 32'(latch_q), 32'h A5);
      chk($sformatf("tbl%0d_lat_en", i), 32'(lat_en),   32'(tbl[i].en));
      chk($sformatf("tbl%0d_lat_d", i),  32'(lat_d),    32'(tbl[i].d));
      chk($sformatf("tbl%0d_ack", i),    32'(ack),      32'(tbl[i].ack));
      chk($sformatf("tbl%0d_busy", i),   32'(busy),     32'(tbl[i].busy));
      chk($sformatf("tbl%0d_gid", i),    32'(grant_id), 32'(tbl[i].gid));
    end
    chk("t1b_latch_q", 32'(latch_q), 32'h5A);

    // Test 2: all four requesting, each dropping for one cycle after its ack.
    do_reset();
    req = 4'hF;
    order.delete();
    budget = 0;
    while (order.size() < 5 && budget < 200) begin
      step();
      budget++;
      if (ack != '0) begin
        chk("t2_ack_onehot", 32'($onehot(ack)), 1);
        chk("t2_ack_vs_gid", 32'(ack), 32'(4'b0001 << grant_id));
        order.push_back(int'(grant_id));
      end
      req = 4'hF & ~ack;
    end
    req = '0;
    chk("t2_count", 32'(order.size()), 5);
    if (order.size() == 5) begin
      chk("t2_g0", 32'(order[0]), 0);
      chk("t2_g1", 32'(order[1]), 1);
      chk("t2_g2", 32'(order[2]), 2);
      chk("t2_g3", 32'(order[3]), 3);
      chk("t2_g4", 32'(order[4]), 0);
    end

    // Test 3: data toggles after grant; the latch must see only the captured value.
    do_reset();
    wdata = {8'h00, 8'h00, 8'h3C, 8'h00};
    req = 4'b0010;
    step();
    chk("t3_gid", 32'(grant_id), 1);
    budget = 0;
    while (busy && budget < 20) begin
      wdata[15:8] = wdata[15:8] ^ 8'hFF;
      step();
      budget++;
      chk($sformatf("t3_lat_d_c%0d", budget), 32'(lat_d), 32'h3C);
      if (ack != '0) req = '0;
    end
    chk("t3_done", 32'(busy), 0);
    chk("t3_latch_q", 32'(latch_q), 32'h3C);

    // Test 4: reset while the enable is open, then ptr must restart at 0.
    do_reset();
    wdata = {8'h00, 8'hC3, 8'h00, 8'h00};
    req = 4'b0100;
    step();
    step();
    chk("t4_open", 32'(lat_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_en",   32'(lat_en), 0);
    chk("t4_async_busy", 32'(busy),   0);
    chk("t4_async_ack",  32'(ack),    0);
    chk("t4_async_d",    32'(lat_d),  0);
    req = 4'b1100;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t4_regrant_gid",  32'(grant_id), 2);
    chk("t4_regrant_busy", 32'(busy),     1);
    budget = 0;
    while (ack == '0 && budget < 20) begin
      step();
      budget++;
    end
    chk("t4_ack", 32'(ack), 32'h4);
    req = '0;
    step();

    // Test 5: EN_CYCLES=1 instance; requester 0 drops req during OPEN.
    do_reset();
    wdata_b = {8'h44, 8'h33, 8'h22, 8'h11};
    req_b = 4'b0111;
    step();
    chk("t5_gid0", 32'(grant_id_b), 0);
    step();
    chk("t5_open", 32'(lat_en_b), 1);
    req_b = 4'b0110;
    step();
    chk("t5_en_closed", 32'(lat_en_b), 0);
    chk("t5_ack0", 32'(ack_b), 32'h1);
    chk("t5_latch_q", 32'(latch_q_b), 32'h11);
    req_b = 4'b0111 & ~ack_b;
    order.delete();
    en_cnt = 0;
    budget = 0;
    while (order.size() < 3 && budget < 100) begin
      step();
      budget++;
      if (lat_en_b) en_cnt++;
      if (ack_b != '0) begin
        order.push_back(int'(grant_id_b));
        chk("t5_en_width", 32'(en_cnt), 1);
        en_cnt = 0;
      end
      req_b = 4'b0111 & ~ack_b;
    end
    req_b = '0;
    chk("t5_count", 32'(order.size()), 3);
    if (order.size() == 3) begin
      chk("t5_g1", 32'(order[0]), 1);
      chk("t5_g2", 32'(order[1]), 2);
      chk("t5_g3", 32'(order[2]), 0);
    end
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
